// File: rtl/alu_bist_signature_compactor.sv
// Compacts a fixed number of ALU result samples into a 32-bit MISR signature.
// It then compares the final signature against a golden value and reports one verdict per run.
module alu_bist_signature_compactor #(
  parameter int unsigned                  DATA_WIDTH     = 32,
  parameter logic [DATA_WIDTH-1:0]        POLY           = 32'h04C11DB7,
  parameter logic [DATA_WIDTH-1:0]        SEED           = 32'hFFFFFFFF,
  parameter int unsigned                  NUM_SAMPLES    = 16,
  parameter int unsigned                  TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [DATA_WIDTH-1:0] golden_sig_i,
  input  logic                  sample_valid_i,
  input  logic [DATA_WIDTH-1:0] sample_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  fail_o,
  output logic                  timeout_o,
  output logic [DATA_WIDTH-1:0] signature_o,
  output logic [15:0]           sample_cnt_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMPARE = 2'd2
  } state_t;

  localparam logic [15:0] LAST_SAMPLE_IDX = 16'(NUM_SAMPLES - 1);
  localparam logic [15:0] LAST_IDLE_IDX   = 16'(TIMEOUT_CYCLES - 1);

  state_t                  state_reg, state_next;
  logic [DATA_WIDTH-1:0]   sig_reg;
  logic [DATA_WIDTH-1:0]   sig_next;
  logic [15:0]             sample_cnt_reg;
  logic [15:0]             idle_cnt_reg;
  logic                    pass_reg, fail_reg, timeout_reg, done_reg;
  logic                    sample_accept;
  logic                    last_sample;
  logic                    timeout_hit;

  // MISR step: shift left, fold in the polynomial on a carry-out, then mix in the sample.
  assign sig_next = {sig_reg[DATA_WIDTH-2:0], 1'b0}
                  ^ (sig_reg[DATA_WIDTH-1] ? POLY : '0)
                  ^ sample_data_i;

  assign sample_accept = (state_reg == COLLECT) && sample_valid_i;
  assign last_sample   = (sample_cnt_reg == LAST_SAMPLE_IDX);
  // >= rather than == so a saturated idle count can never skip past the limit.
  assign timeout_hit   = (state_reg == COLLECT) && !sample_valid_i
                       && (idle_cnt_reg >= LAST_IDLE_IDX);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (abort_i) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_i) state_next = COLLECT;
        end
        COLLECT: begin
          if (sample_accept && last_sample) state_next = COMPARE;
          else if (timeout_hit)             state_next = IDLE;
        end
        COMPARE: state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o = (state_reg == COLLECT) || (state_reg == COMPARE);
  end

  // Abort clears the verdict but keeps signature and count visible for debug.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sig_reg        <= '0;
      sample_cnt_reg <= '0;
      idle_cnt_reg   <= '0;
      pass_reg       <= 1'b0;
      fail_reg       <= 1'b0;
      timeout_reg    <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (abort_i) begin
        pass_reg    <= 1'b0;
        fail_reg    <= 1'b0;
        timeout_reg <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start_i) begin
              sig_reg        <= SEED;
              sample_cnt_reg <= '0;
              idle_cnt_reg   <= '0;
              pass_reg       <= 1'b0;
              fail_reg       <= 1'b0;
              timeout_reg    <= 1'b0;
            end
          end
          COLLECT: begin
            if (sample_valid_i) begin
              sig_reg        <= sig_next;
              sample_cnt_reg <= sample_cnt_reg + 16'd1;
              idle_cnt_reg   <= '0;
            end else begin
              if (idle_cnt_reg != 16'hFFFF) idle_cnt_reg <= idle_cnt_reg + 16'd1;
              if (timeout_hit) begin
                fail_reg    <= 1'b1;
                timeout_reg <= 1'b1;
                done_reg    <= 1'b1;
              end
            end
          end
          COMPARE: begin
            pass_reg <= (sig_reg == golden_sig_i);
            fail_reg <= (sig_reg != golden_sig_i);
            done_reg <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign done_o       = done_reg;
  assign pass_o       = pass_reg;
  assign fail_o       = fail_reg;
  assign timeout_o    = timeout_reg;
  assign signature_o  = sig_reg;
  assign sample_cnt_o = sample_cnt_reg;

endmodule

// File: tb/tb_alu_bist_signature_compactor.sv
// Directed bench: a single-sample instance (verdicts, timeout, abort) and a
// 16-sample instance (bubbled streaming, start while busy, reset mid-run).
module tb_alu_bist_signature_compactor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_start, a_abort, a_valid;
  logic [31:0] a_golden, a_data;
  logic        a_busy, a_done, a_pass, a_fail, a_timeout;
  logic [31:0] a_sig;
  logic [15:0] a_cnt;

  logic        b_start, b_abort, b_valid;
  logic [31:0] b_golden, b_data;
  logic        b_busy, b_done, b_pass, b_fail, b_timeout;
  logic [31:0] b_sig;
  logic [15:0] b_cnt;

  alu_bist_signature_compactor #(.NUM_SAMPLES(1), .TIMEOUT_CYCLES(8)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(a_start), .abort_i(a_abort),
    .golden_sig_i(a_golden), .sample_valid_i(a_valid), .sample_data_i(a_data),
    .busy_o(a_busy), .done_o(a_done), .pass_o(a_pass), .fail_o(a_fail),
    .timeout_o(a_timeout), .signature_o(a_sig), .sample_cnt_o(a_cnt)
  );

  alu_bist_signature_compactor #(.NUM_SAMPLES(16), .TIMEOUT_CYCLES(8)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(b_start), .abort_i(b_abort),
    .golden_sig_i(b_golden), .sample_valid_i(b_valid), .sample_data_i(b_data),
    .busy_o(b_busy), .done_o(b_done), .pass_o(b_pass), .fail_o(b_fail),
    .timeout_o(b_timeout), .signature_o(b_sig), .sample_cnt_o(b_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] misr(input logic [31:0] s, input logic [31:0] d);
    return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ d;
  endfunction

  logic [31:0] model;
  int accepted, dcount, cyc, bubbles;
  logic took;

  initial begin
    rst = 1'b1;
    a_start = 0; a_abort = 0; a_valid = 0; a_golden = 0; a_data = 0;
    b_start = 0; b_abort = 0; b_valid = 0; b_golden = 0; b_data = 0;
    tick; tick;
    rst = 1'b0;
    chk("reset_sig", a_sig, 32'h0);
    chk("reset_cnt", a_cnt, 32'h0);
    chk("reset_busy", a_busy, 0);
    chk("reset_flags", {a_done, a_pass, a_fail, a_timeout}, 0);
    $display("txn reset: sig=%h cnt=%0d", a_sig, a_cnt);

    // Fault-free single sample
    a_start = 1; tick; a_start = 0;
    chk("start_busy", a_busy, 1);
    chk("start_seed", a_sig, 32'hFFFFFFFF);
    a_valid = 1; a_data = 32'hFFFFFFFF; a_golden = 32'h04C11DB6; tick; a_valid = 0;
    chk("good_sig", a_sig, 32'h04C11DB6);
    chk("good_cnt", a_cnt, 1);
    chk("good_no_done_yet", a_done, 0);
    tick;
    chk("good_done", a_done, 1);
    chk("good_pass_fail", {a_pass, a_fail, a_busy}, 3'b100);
    $display("txn good: sig=%h pass=%b fail=%b", a_sig, a_pass, a_fail);
    tick;
    chk("good_done_drop", a_done, 0);
    chk("good_pass_sticky", a_pass, 1);

    // Injected fault
    a_start = 1; tick; a_start = 0;
    a_valid = 1; a_data = 32'hFFFFFFFE; tick; a_valid = 0;
    chk("fault_sig", a_sig, 32'h04C11DB7);
    tick;
    chk("fault_flags", {a_done, a_pass, a_fail, a_timeout}, 4'b1010);
    $display("txn fault: sig=%h pass=%b fail=%b", a_sig, a_pass, a_fail);

    // Zero sample, started back-to-back in the done cycle
    a_start = 1; tick; a_start = 0;
    chk("b2b_busy", a_busy, 1);
    chk("b2b_flags_cleared", {a_pass, a_fail}, 0);
    a_valid = 1; a_data = 32'h0; a_golden = 32'hFB3EE249; tick; a_valid = 0;
    chk("zero_sig", a_sig, 32'hFB3EE249);
    tick;
    chk("zero_pass", {a_done, a_pass, a_fail}, 3'b110);
    $display("txn zero: sig=%h pass=%b", a_sig, a_pass);

    // Timeout: 8 COLLECT cycles with no sample
    a_start = 1; tick; a_start = 0;
    for (int i = 0; i < 7; i++) begin
      tick;
      chk("timeout_early_done", a_done, 0);
    end
    tick;
    chk("timeout_flags", {a_done, a_pass, a_fail, a_timeout, a_busy}, 5'b10110);
    chk("timeout_cnt", a_cnt, 0);
    chk("timeout_sig_held", a_sig, 32'hFFFFFFFF);
    $display("txn timeout: fail=%b timeout=%b cnt=%0d", a_fail, a_timeout, a_cnt);

    // Abort together with the final sample
    a_start = 1; tick; a_start = 0;
    a_valid = 1; a_data = 32'h0; a_abort = 1; tick; a_valid = 0; a_abort = 0;
    chk("abort_busy", a_busy, 0);
    chk("abort_flags", {a_done, a_pass, a_fail, a_timeout}, 0);
    chk("abort_sig_held", a_sig, 32'hFFFFFFFF);
    chk("abort_cnt_held", a_cnt, 0);
    tick;
    chk("abort_no_done", {a_done, a_busy}, 0);
    $display("txn abort: busy=%b done=%b", a_busy, a_done);

    // Start and abort together in IDLE
    a_start = 1; a_abort = 1; tick; a_start = 0; a_abort = 0;
    chk("start_abort_idle", a_busy, 0);
    tick;
    chk("start_abort_still_idle", {a_busy, a_done}, 0);
    $display("txn start+abort: busy=%b", a_busy);

    // 16 samples with random bubbles, plus a start while busy
    b_start = 1; tick; b_start = 0;
    model = 32'hFFFFFFFF; accepted = 0; dcount = 0; cyc = 0; bubbles = 0;
    while (accepted < 16 && cyc < 200) begin
      b_valid = (bubbles >= 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
      b_data  = $urandom;
      b_start = (cyc == 5);
      took = b_valid;
      if (took) model = misr(model, b_data);
      tick;
      if (took) begin accepted++; bubbles = 0; end else bubbles++;
      if (b_done) dcount++;
      if (cyc == 5) begin
        chk("start_busy_cnt", b_cnt, accepted);
        chk("start_busy_sig", b_sig, model);
      end
      cyc++;
    end
    b_valid = 0; b_start = 0;
    chk("stream_budget", accepted, 16);
    chk("stream_sig", b_sig, model);
    chk("stream_cnt", b_cnt, 16);
    chk("stream_compare_busy", b_busy, 1);
    b_golden = model;
    tick;
    if (b_done) dcount++;
    chk("stream_verdict", {b_done, b_pass, b_fail, b_busy}, 4'b1100);
    for (int i = 0; i < 3; i++) begin
      b_valid = 1; b_data = 32'h5A5A5A5A;
      tick;
      if (b_done) dcount++;
    end
    b_valid = 0;
    chk("stream_one_done", dcount, 1);
    chk("stream_cnt_capped", b_cnt, 16);
    $display("txn stream16: sig=%h cnt=%0d cycles=%0d dones=%0d", b_sig, b_cnt, cyc, dcount);

    // Reset mid-COLLECT
    b_start = 1; tick; b_start = 0;
    b_valid = 1; b_data = 32'h12345678; tick; tick; b_valid = 0;
    chk("pre_reset_cnt", b_cnt, 2);
    rst = 1; tick; rst = 0;
    chk("midrst_sig", b_sig, 0);
    chk("midrst_cnt", b_cnt, 0);
    chk("midrst_flags", {b_busy, b_done, b_pass, b_fail, b_timeout}, 0);
    tick;
    chk("midrst_idle", {b_busy, b_done}, 0);
    $display("txn reset-midrun: sig=%h cnt=%0d busy=%b", b_sig, b_cnt, b_busy);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
